// File: rtl/spi_flash_responder_pkg.sv
// Shared definitions for the SPI NOR flash responder and the matching initiator side:
// command opcodes, FSM states and the JEDEC ID byte selector.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_JEDEC  = 8'h9F;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RD_OUT = 3'd3,
    ST_ID_OUT = 3'd4,
    ST_ST_OUT = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  // Bytes 0..2 are the ID MSB first; anything later reads as zero.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      2'd2:    id_byte = id[7:0];
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus rise/fall detection
// against a third flop; RST_VAL is the idle level of the pin.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= {3{RST_VAL}};
    else     sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a minimal NOR flash: JEDEC ID (0x9F),
// status (0x05) and sequential READ (0x03) served from a 1-cycle-latency memory port.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00,
  parameter int          ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              busy
);

  state_t      state, state_next;
  logic        ss_q, ss_rise, ss_fall;
  logic        sck_q, sck_rise, sck_fall;
  logic [1:0]  mosi_sync;
  logic        bit_tick, byte_done;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_next;
  logic [15:0] addr_shift;
  logic [23:0] full_addr;
  logic [1:0]  addr_cnt, id_cnt;
  logic        rd_pend, load_pend;
  logic [7:0]  tx_next;
  logic [6:0]  tx_shift;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss  (.clk(clk), .rst(rst), .d(ss_n), .q(ss_q),  .rise(ss_rise),  .fall(ss_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(clk), .rst(rst), .d(sck),  .q(sck_q), .rise(sck_rise), .fall(sck_fall));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync <= 2'b00;
    else     mosi_sync <= {mosi_sync[0], mosi};
  end

  assign bit_tick  = sck_rise & sck_q;
  assign rx_next   = {rx_shift, mosi_sync[1]};
  assign byte_done = bit_tick & (bit_cnt == 3'd7) & (state != ST_IDLE) & ~ss_q;
  assign full_addr = {addr_shift, rx_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_IDLE) begin
      if (ss_fall) state_next = ST_CMD;
      else         state_next = ST_IDLE;
    end else if (ss_rise) begin
      state_next = ST_IDLE;
    end else if (byte_done) begin
      case (state)
        ST_CMD: begin
          case (rx_next)
            CMD_READ:   state_next = ST_ADDR;
            CMD_JEDEC:  state_next = ST_ID_OUT;
            CMD_STATUS: state_next = ST_ST_OUT;
            default:    state_next = ST_IGNORE;
          endcase
        end
        ST_ADDR: begin
          if (addr_cnt == 2'd2) state_next = ST_RD_OUT;
          else                  state_next = ST_ADDR;
        end
        default: state_next = state;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Bit engine, command/address decode, memory strobe and MISO shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_byte    <= 8'h00;
      rx_shift   <= 7'h00;
      bit_cnt    <= 3'd0;
      rd_req     <= 1'b0;
      rd_pend    <= 1'b0;
      rd_addr    <= '0;
      addr_shift <= 16'h0000;
      addr_cnt   <= 2'd0;
      id_cnt     <= 2'd0;
      load_pend  <= 1'b0;
      tx_next    <= 8'h00;
      tx_shift   <= 7'h00;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
    end else begin
      busy     <= ~ss_q;
      rx_valid <= 1'b0;
      rd_req   <= 1'b0;
      rd_pend  <= rd_req;
      if (rd_pend) tx_next <= rd_data;
      if (ss_rise) begin
        bit_cnt   <= 3'd0;
        addr_cnt  <= 2'd0;
        id_cnt    <= 2'd0;
        load_pend <= 1'b0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        if (bit_tick && state != ST_IDLE) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_next[6:0];
        end
        if (byte_done) begin
          rx_byte  <= rx_next;
          rx_valid <= 1'b1;
          case (state)
            ST_CMD: begin
              case (rx_next)
                CMD_READ:   addr_cnt <= 2'd0;
                CMD_JEDEC: begin
                  tx_next   <= id_byte(JEDEC_ID, 2'd0);
                  id_cnt    <= 2'd1;
                  load_pend <= 1'b1;
                end
                CMD_STATUS: begin
                  tx_next   <= STATUS;
                  load_pend <= 1'b1;
                end
                default: load_pend <= 1'b0;
              endcase
            end
            ST_ADDR: begin
              if (addr_cnt == 2'd2) begin
                rd_req    <= 1'b1;
                rd_addr   <= full_addr[ADDR_W-1:0];
                load_pend <= 1'b1;
                addr_cnt  <= 2'd0;
              end else begin
                addr_shift <= {addr_shift[7:0], rx_next};
                addr_cnt   <= addr_cnt + 2'd1;
              end
            end
            ST_RD_OUT: begin
              rd_req    <= 1'b1;
              rd_addr   <= rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              load_pend <= 1'b1;
            end
            ST_ID_OUT: begin
              tx_next   <= id_byte(JEDEC_ID, id_cnt);
              load_pend <= 1'b1;
              if (id_cnt != 2'd3) id_cnt <= id_cnt + 2'd1;
            end
            ST_ST_OUT: begin
              tx_next   <= STATUS;
              load_pend <= 1'b1;
            end
            default: load_pend <= load_pend;
          endcase
        end
        // A pending byte is presented at the first SCK fall after it was decided.
        if (sck_fall) begin
          if (load_pend) begin
            tx_shift  <= tx_next[6:0];
            miso      <= tx_next[7];
            miso_oe   <= 1'b1;
            load_pend <= 1'b0;
          end else if (miso_oe) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
            miso     <= tx_shift[6];
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI mode-0 target (responder) that answers a bus initiator such as the iCE40 flash bit-banger, emulating a minimal SPI NOR flash. It oversamples SS/SCK/MOSI in the `clk` domain and decodes the command byte. It serves JEDEC ID, status and sequential READ from a synchronous memory port. It sits between the SPI pins (ICE_SS/ICE_SCK/ICE_MOSI/ICE_MISO side) and an on-chip RAM/ROM.

Parameters:
JEDEC_ID, 24'hEF4016, bytes returned for 0x9F, MSB byte first
STATUS, 8'h00, byte returned repeatedly for 0x05
ADDR_W, 24, memory address width; READ takes 3 address bytes, low ADDR_W bits used

Ports:
clk  input  1  system clock; SCK high and low phases each >= 4 clk periods
rst  input  1  asynchronous, active-high reset
ss_n  input  1  SPI chip select, active low, asynchronous to clk
sck  input  1  SPI clock, mode 0 (idle low)
mosi  input  1  SPI data in, sampled on SCK rising edge
miso  output  1  SPI data out, changes after SCK falling edge
miso_oe  output  1  1 = drive miso pad, 0 = tristate
rd_req  output  1  1-cycle read strobe to memory
rd_addr  output  ADDR_W  read address, valid with rd_req
rd_data  input  8  memory data, valid exactly 1 clk after rd_req
rx_byte  output  8  last complete byte received on MOSI
rx_valid  output  1  1-cycle pulse when rx_byte updates
busy  output  1  1 while ss_n (synchronised) is low

Behaviour:
- Reset values: miso=0, miso_oe=0, rd_req=0, rd_addr=0, rx_byte=0, rx_valid=0, busy=0, FSM=IDLE, counters=0.
- Synchronisation: ss_n, sck and mosi each pass through a 2-FF synchroniser. Edges are detected against a third register. Edge-to-action latency is 3 clk.
- Bit engine: on each SCK rise, shift mosi into rx shift register MSB-first and increment the 3-bit counter. On the 8th rise, update rx_byte and pulse rx_valid for one cycle. The counter then wraps to 0.
- TX shift: on each SCK fall, if miso_oe=1, shift left and miso <= next MSB. A new byte is loaded at the fall following the 8th rise. Its MSB appears on miso immediately at load.
- FSM states: IDLE, CMD, ADDR, RD_OUT, ID_OUT, ST_OUT, IGNORE.
  - IDLE -> CMD on ss_n fall.
  - CMD, on byte done: 0x03 -> ADDR (addr byte count 0). 0x9F -> ID_OUT (load JEDEC_ID[23:16]). 0x05 -> ST_OUT (load STATUS). Any other value -> IGNORE.
  - ADDR: collect 3 bytes MSB-first into a 24-bit address. On the 3rd byte, go to RD_OUT and issue rd_req with rd_addr = address. The rd_data captured next cycle loads at the following SCK fall.
  - RD_OUT: on each byte done, address increments by 1 (wraps all-ones -> 0 at ADDR_W). Issue rd_req for the new address and load the result at the next fall.
  - ID_OUT: bytes JEDEC_ID[23:16], [15:8], [7:0], then 0x00 for every later byte.
  - ST_OUT: STATUS repeated every byte.
  - IGNORE: receive only, no output.
- miso_oe=1 only in RD_OUT/ID_OUT/ST_OUT, from the load fall onward. miso=0 whenever miso_oe=0.
- ss_n rise in any state, including mid-byte: go to IDLE the cycle after detection. Clear bit and byte counters and drop miso_oe. No rx_valid for a partial byte. No rd_req is issued after ss_n is detected high.
- rx_valid pulses for every complete byte in every non-IDLE state, including address bytes and bytes clocked during output phases.
- rst asserted at any time forces all reset values immediately. The next transaction starts cleanly only after the next ss_n fall.

Decomposition:
- Shared package: command opcode constants (CMD_READ=8'h03, CMD_JEDEC=8'h9F, CMD_STATUS=8'h05) and the FSM state enum. The flash initiator side reuses these.
- One natural sub-module, spi_sync_edge: a 2-FF synchroniser plus rise/fall edge detect, instantiated for sck and ss_n. mosi uses the sync part only.

Test Plan:
1. JEDEC: ss_n low, send 0x9F, then clock 32 bits -> miso bytes EF 40 16 00. rx_valid pulses 5 times, first rx_byte=9F.
2. Read: send 03 00 01 00, then 4 bytes; memory model returns addr[7:0]^8'h5A -> rd_addr 000100, 000101, 000102, 000103 (one rd_req each), miso 5A 5B 58 59.
3. Wrap: read from FFFFFF for 2 bytes -> rd_addr FFFFFF then 000000.
4. Status with STATUS=8'h02: send 05, then 3 bytes -> miso 02 02 02, miso_oe=1 throughout the output.
5. Unknown/abort: send AA -> IGNORE, miso_oe=0, rx_byte=AA. Then raise ss_n after 5 bits of a 9F transaction -> IDLE, no rx_valid for the partial byte. A following full 9F transaction returns EF 40 16.
6. Reset mid-read: assert rst during RD_OUT byte 2 -> miso, miso_oe, rd_req and busy all 0 with no clk edge required. After release, a new 0x9F transaction works.
